// File: rtl/programmable_fault_injector.sv
// programmable_fault_injector: flips one, two or a burst of codeword bits in a delay/repeat window.
// Define FI_LFSR_EN to take the base bit index from a 16-bit LFSR instead of cfg_addr_a.
module programmable_fault_injector #(
  parameter int          CODE_W    = 12,
  parameter int          ADDR_W    = 4,
  parameter int          CNT_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [ADDR_W-1:0] cfg_addr_a,
  input  logic [ADDR_W-1:0] cfg_addr_b,
  input  logic [ADDR_W-1:0] cfg_burst_len,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_repeat,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  output logic [CODE_W-1:0] out_fault_mask,
  output logic              out_injected,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_INJECT, S_DONE} state_e;

  if (LFSR_SEED == 16'h0 || (1 << ADDR_W) < CODE_W || CODE_W < 2) begin : g_param_check
    $error("programmable_fault_injector: illegal parameter set");
  end

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   b_q, b_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]    rep_q, rep_d;
  logic [CNT_W-1:0]    dly_cnt_q, dly_cnt_d;
  logic [CNT_W-1:0]    rep_cnt_q, rep_cnt_d;
  logic                accept;
  int                  a_eff;
  logic [CODE_W-1:0]   mask_now;
  logic                out_valid_q;
  logic [CODE_W-1:0]   out_code_q, out_mask_q;

  assign accept = cfg_valid && (state_q == S_IDLE);

`ifdef FI_LFSR_EN
  logic        fault_beat;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] a_mod;

  assign fault_beat = (state_q == S_INJECT) && in_valid;
  assign lfsr_d     = fault_beat ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                                 : lfsr_q;
  assign a_mod      = lfsr_q % 16'(CODE_W);
  assign a_eff      = int'(a_mod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`else
  logic [ADDR_W-1:0] a_q, a_d;

  assign a_d   = accept ? cfg_addr_a : a_q;
  assign a_eff = int'(a_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) a_q <= '0;
    else     a_q <= a_d;
  end
`endif

  // Bit j is in a burst when its wrapped distance from the base index is below the length.
  function automatic logic [CODE_W-1:0] build_mask(input logic [1:0] mode, input int a,
                                                   input int b, input int len);
    logic [CODE_W-1:0] m;
    int                off;
    m = '0;
    for (int j = 0; j < CODE_W; j++) begin
      off = (j >= a) ? j - a : j + CODE_W - a;
      case (mode)
        2'd1:    m[j] = (j == a);
        2'd2:    m[j] = (j == a) || (j == b);
        2'd3:    m[j] = (a < CODE_W) && (off < len);
        default: m[j] = 1'b0;
      endcase
    end
    return m;
  endfunction

  assign mask_now = (state_q == S_INJECT) ? build_mask(mode_q, a_eff, int'(b_q), int'(len_q)) : '0;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    b_d       = b_q;
    len_d     = len_q;
    rep_d     = rep_q;
    dly_cnt_d = dly_cnt_q;
    rep_cnt_d = rep_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          mode_d    = cfg_mode;
          b_d       = cfg_addr_b;
          len_d     = cfg_burst_len;
          rep_d     = cfg_repeat;
          dly_cnt_d = cfg_delay;
          rep_cnt_d = cfg_repeat;
          if (cfg_mode != 2'd0) state_d = (cfg_delay == '0) ? S_INJECT : S_DELAY;
        end
      end
      S_DELAY: begin
        if (in_valid) begin
          dly_cnt_d = dly_cnt_q - CNT_W'(1);
          if (dly_cnt_q == CNT_W'(1)) state_d = S_INJECT;
        end
        if (abort) state_d = S_IDLE;
      end
      S_INJECT: begin
        if (in_valid && rep_q != '0) begin
          rep_cnt_d = rep_cnt_q - CNT_W'(1);
          if (rep_cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
        if (abort) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      b_q       <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      dly_cnt_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      b_q       <= b_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      dly_cnt_q <= dly_cnt_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  // Output stage: one register between input beat and faulted codeword
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_mask_q  <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_code_q <= in_code ^ mask_now;
        out_mask_q <= mask_now;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_code       = out_code_q;
  assign out_fault_mask = out_mask_q;
  assign out_injected   = |out_mask_q;
  assign cfg_ready      = (state_q == S_IDLE);
  assign busy           = (state_q == S_DELAY) || (state_q == S_INJECT);
  assign done           = (state_q == S_DONE);

endmodule
